// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared sizing helpers, index type and reset value for the register file
package rf_pkg;

    // Index width for a DEPTH-entry file; never narrower than one bit.
    function automatic int rf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width able to hold any pending count from 0 to DEPTH inclusive.
    function automatic int rf_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Loop index over register entries.
    typedef int unsigned rf_idx_t;

    // Every register and status bit clears to zero.
    localparam logic RF_RESET_BIT = 1'b0;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-bit scoreboard with pending count and sticky reservation error
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en, wr_addr        effective writeback (already masked for the zero register)
//   rsv_en, rsv_addr      effective reservation (already masked for the zero register)
//   a_addr, b_addr        read port indices
//   a_pend, b_pend        raw pending bit of each read port's register
//   pending_count         registered number of pending registers
//   rsv_err               sticky: a reservation hit a register still pending
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = rf_aw(DEPTH),
    localparam int CW = rf_cw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    output logic          a_pend,
    output logic          b_pend,
    output logic [CW-1:0] pending_count,
    output logic          rsv_err
);

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rsv_err_q, rsv_err_d;

    always_comb begin
        pending_d = pending_q;
        // Clear before set: a reservation landing with the retiring write
        // to the same register supersedes it and leaves the bit set.
        if (wr_en) begin
            pending_d[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            pending_d[rsv_addr] = 1'b1;
        end

        // Double reservation is only an error if the old result is not
        // retiring on this very edge.
        rsv_err_d = rsv_err_q
                  | (rsv_en && pending_q[rsv_addr] && !(wr_en && (wr_addr == rsv_addr)));

        // Counting the next-state vector keeps the count exact by construction.
        count_d = '0;
        for (rf_idx_t i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(pending_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= {DEPTH{RF_RESET_BIT}};
            count_q   <= {CW{RF_RESET_BIT}};
            rsv_err_q <= RF_RESET_BIT;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            rsv_err_q <= rsv_err_d;
        end
    end

    assign a_pend        = pending_q[a_addr];
    assign b_pend        = pending_q[b_addr];
    assign pending_count = count_q;
    assign rsv_err       = rsv_err_q;

endmodule

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - two-read/one-write register file with bypass, optional zero register and scoreboard
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   wrEn, wrAddr, wrData    writeback port
//   rsvEn, rsvAddr          reserve a register for an in-flight result
//   aAddr/aData/aBusy       read port A: combinational data and RAW-hazard flag
//   bAddr/bData/bBusy       read port B: combinational data and RAW-hazard flag
//   pendingCount            registered count of pending registers
//   rsvErr                  sticky double-reservation flag
module register_file_sb
    import rf_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    localparam int AW = rf_aw(DEPTH),
    localparam int CW = rf_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rsvEn,
    input  logic [AW-1:0]    rsvAddr,
    input  logic [AW-1:0]    aAddr,
    input  logic [AW-1:0]    bAddr,
    output logic [WIDTH-1:0] aData,
    output logic [WIDTH-1:0] bData,
    output logic             aBusy,
    output logic             bBusy,
    output logic [CW-1:0]    pendingCount,
    output logic             rsvErr
);

    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];

    logic wr_eff;
    logic rsv_eff;
    logic a_pend;
    logic b_pend;

    // Register 0 swallows writes and reservations when hardwired to zero.
    assign wr_eff  = wrEn  && !(HAS_ZERO && (wrAddr  == '0));
    assign rsv_eff = rsvEn && !(HAS_ZERO && (rsvAddr == '0));

    always_comb begin
        regs_d = regs_q;
        if (wr_eff) begin
            regs_d[wrAddr] = wrData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (rf_idx_t i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {WIDTH{RF_RESET_BIT}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_eff),
        .wr_addr       (wrAddr),
        .rsv_en        (rsv_eff),
        .rsv_addr      (rsvAddr),
        .a_addr        (aAddr),
        .b_addr        (bAddr),
        .a_pend        (a_pend),
        .b_pend        (b_pend),
        .pending_count (pendingCount),
        .rsv_err       (rsvErr)
    );

    // Read priority: held in reset, hardwired zero, same-cycle writeback
    // bypass (result is arriving, so no hazard), then stored value.
    always_comb begin
        aData = '0;
        aBusy = 1'b0;
        if (!rst_n || (HAS_ZERO && (aAddr == '0))) begin
            aData = '0;
        end else if (wrEn && (wrAddr == aAddr)) begin
            aData = wrData;
        end else begin
            aData = regs_q[aAddr];
            aBusy = a_pend;
        end
    end

    always_comb begin
        bData = '0;
        bBusy = 1'b0;
        if (!rst_n || (HAS_ZERO && (bAddr == '0))) begin
            bData = '0;
        end else if (wrEn && (wrAddr == bAddr)) begin
            bData = wrData;
        end else begin
            bData = regs_q[bAddr];
            bBusy = b_pend;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - self-checking bench for register_file_sb over three configurations
module tb_register_file_sb;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [2:0]  a_addr;
    logic [2:0]  b_addr;

    // Instance 0: 8x4 plain; 1: 8x4 zero register; 2: 16x8 plain.
    logic [7:0]  a_data0, b_data0, a_data1, b_data1;
    logic [15:0] a_data2, b_data2;
    logic        a_busy0, b_busy0, a_busy1, b_busy1, a_busy2, b_busy2;
    logic [2:0]  cnt0, cnt1;
    logic [3:0]  cnt2;
    logic        err0, err1, err2;

    int cfg_w [3] = '{8, 8, 16};
    int cfg_d [3] = '{4, 4, 8};
    int cfg_z [3] = '{0, 1, 0};

    int n_cmp  = 0;
    int n_fail = 0;

    register_file_sb #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wrEn(wr_en), .wrAddr(wr_addr[1:0]), .wrData(wr_data[7:0]),
        .rsvEn(rsv_en), .rsvAddr(rsv_addr[1:0]), .aAddr(a_addr[1:0]), .bAddr(b_addr[1:0]),
        .aData(a_data0), .bData(b_data0), .aBusy(a_busy0), .bBusy(b_busy0),
        .pendingCount(cnt0), .rsvErr(err0));

    register_file_sb #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wrEn(wr_en), .wrAddr(wr_addr[1:0]), .wrData(wr_data[7:0]),
        .rsvEn(rsv_en), .rsvAddr(rsv_addr[1:0]), .aAddr(a_addr[1:0]), .bAddr(b_addr[1:0]),
        .aData(a_data1), .bData(b_data1), .aBusy(a_busy1), .bBusy(b_busy1),
        .pendingCount(cnt1), .rsvErr(err1));

    register_file_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
        .rsvEn(rsv_en), .rsvAddr(rsv_addr), .aAddr(a_addr), .bAddr(b_addr),
        .aData(a_data2), .bData(b_data2), .aBusy(a_busy2), .bBusy(b_busy2),
        .pendingCount(cnt2), .rsvErr(err2));

    logic [15:0] act_a [3];
    logic [15:0] act_b [3];
    logic        act_ab [3];
    logic        act_bb [3];
    logic [3:0]  act_c [3];
    logic        act_e [3];

    assign act_a[0] = {8'h00, a_data0};
    assign act_a[1] = {8'h00, a_data1};
    assign act_a[2] = a_data2;
    assign act_b[0] = {8'h00, b_data0};
    assign act_b[1] = {8'h00, b_data1};
    assign act_b[2] = b_data2;
    assign act_ab[0] = a_busy0;
    assign act_ab[1] = a_busy1;
    assign act_ab[2] = a_busy2;
    assign act_bb[0] = b_busy0;
    assign act_bb[1] = b_busy1;
    assign act_bb[2] = b_busy2;
    assign act_c[0] = {1'b0, cnt0};
    assign act_c[1] = {1'b0, cnt1};
    assign act_c[2] = cnt2;
    assign act_e[0] = err0;
    assign act_e[1] = err1;
    assign act_e[2] = err2;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: architectural register contents and pending set.
    bit [15:0] m_reg  [3][8];
    bit        m_pend [3][8];
    bit        m_err  [3];

    function automatic int ma(int k, logic [2:0] x);
        return int'(x) & (cfg_d[k] - 1);
    endfunction

    function automatic logic [15:0] md(int k, logic [15:0] d);
        return (cfg_w[k] == 8) ? {8'h00, d[7:0]} : d;
    endfunction

    function automatic logic [15:0] exp_data(int k, logic [2:0] x);
        int i;
        i = ma(k, x);
        if (!rst_n || (cfg_z[k] != 0 && i == 0)) return 16'h0000;
        if (wr_en && ma(k, wr_addr) == i) return md(k, wr_data);
        return m_reg[k][i];
    endfunction

    function automatic logic exp_busy(int k, logic [2:0] x);
        int i;
        i = ma(k, x);
        if (!rst_n || (cfg_z[k] != 0 && i == 0)) return 1'b0;
        if (wr_en && ma(k, wr_addr) == i) return 1'b0;
        return m_pend[k][i];
    endfunction

    function automatic logic [3:0] exp_cnt(int k);
        int c;
        c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_pend[k][i]);
        return 4'(c);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int  w;
            int  r;
            bit  we;
            bit  re;
            if (!rst_n) begin
                m_err[k] = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    m_reg[k][i]  = 16'h0000;
                    m_pend[k][i] = 1'b0;
                end
            end else begin
                w  = ma(k, wr_addr);
                r  = ma(k, rsv_addr);
                we = wr_en  && !(cfg_z[k] != 0 && w == 0);
                re = rsv_en && !(cfg_z[k] != 0 && r == 0);
                if (re && m_pend[k][r] && !(we && w == r)) m_err[k] = 1'b1;
                if (we) begin
                    m_reg[k][w]  = md(k, wr_data);
                    m_pend[k][w] = 1'b0;
                end
                if (re) m_pend[k][r] = 1'b1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_edge();
        end
    end

    task automatic check(string name, int k, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // Compare process: every cycle, well after inputs settle and before the next edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            for (int k = 0; k < 3; k++) begin
                check("aData", k, act_a[k], exp_data(k, a_addr));
                check("bData", k, act_b[k], exp_data(k, b_addr));
                check("aBusy", k, 16'(act_ab[k]), 16'(exp_busy(k, a_addr)));
                check("bBusy", k, 16'(act_bb[k]), 16'(exp_busy(k, b_addr)));
                check("pendingCount", k, 16'(act_c[k]), 16'(exp_cnt(k)));
                check("rsvErr", k, 16'(act_e[k]), 16'(m_err[k]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
        rsv_en = 1'b0; rsv_addr = 3'd0; a_addr = 3'd0; b_addr = 3'd1;

        // Reset state
        tick(); tick();
        #1;
        check("rst_aData", 0, act_a[0], 16'h0);
        check("rst_bBusy", 0, 16'(b_busy0), 16'h0);
        check("rst_cnt", 0, 16'(cnt0), 16'h0);
        check("rst_err", 0, 16'(err0), 16'h0);

        // Plain writes then reads
        tick(); rst_n = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00A5;
        tick(); wr_addr = 3'd3; wr_data = 16'h003C;
        tick(); idle(); a_addr = 3'd2; b_addr = 3'd3;
        #1;
        check("rd_a_r2", 0, act_a[0], 16'h00A5);
        check("rd_b_r3", 0, act_b[0], 16'h003C);

        // Bypass
        tick(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0011;
        tick(); wr_data = 16'h0077; a_addr = 3'd1;
        #1;
        check("bypass_comb", 0, act_a[0], 16'h0077);
        tick(); idle();
        #1;
        check("bypass_stored", 0, act_a[0], 16'h0077);

        // Scoreboard reserve / retire
        tick(); rsv_en = 1'b1; rsv_addr = 3'd2;
        tick(); idle(); a_addr = 3'd2;
        #1;
        check("sb_busy", 0, 16'(a_busy0), 16'h1);
        check("sb_cnt1", 0, 16'(cnt0), 16'h1);
        tick(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0042;
        #1;
        check("sb_wr_bypass_busy", 0, 16'(a_busy0), 16'h0);
        check("sb_wr_cnt", 0, 16'(cnt0), 16'h1);
        tick(); idle();
        #1;
        check("sb_retired_busy", 0, 16'(a_busy0), 16'h0);
        check("sb_retired_data", 0, act_a[0], 16'h0042);
        check("sb_cnt0", 0, 16'(cnt0), 16'h0);

        // Same-cycle write + reserve of a pending register, then a double reserve
        tick(); rsv_en = 1'b1; rsv_addr = 3'd3;
        tick(); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h005A;
        tick(); idle(); a_addr = 3'd3;
        #1;
        check("wr_rsv_data", 0, act_a[0], 16'h005A);
        check("wr_rsv_busy", 0, 16'(a_busy0), 16'h1);
        check("wr_rsv_cnt", 0, 16'(cnt0), 16'h1);
        check("wr_rsv_err", 0, 16'(err0), 16'h0);
        tick(); rsv_en = 1'b1; rsv_addr = 3'd3;
        tick(); idle();
        #1;
        check("dbl_rsv_err", 0, 16'(err0), 16'h1);
        tick(); wr_en = 1'b1; wr_addr = 3'd3;
        tick(); idle(); tick();
        #1;
        check("err_sticky", 0, 16'(err0), 16'h1);

        // Zero register
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h00FF;
        rsv_en = 1'b1; rsv_addr = 3'd0; a_addr = 3'd0;
        #1;
        check("z_comb_data", 1, act_a[1], 16'h0);
        check("nz_comb_data", 0, act_a[0], 16'h00FF);
        tick(); idle();
        #1;
        check("z_data", 1, act_a[1], 16'h0);
        check("z_busy", 1, 16'(a_busy1), 16'h0);
        check("z_cnt", 1, 16'(cnt1), 16'h0);
        check("nz_busy", 0, 16'(a_busy0), 16'h1);
        check("nz_cnt", 0, 16'(cnt0), 16'h1);

        // Asynchronous reset mid-operation on the 16x8 instance
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; rsv_en = 1'b1; rsv_addr = 3'd1;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hBEEF;
        tick(); wr_en = 1'b0; rsv_addr = 3'd5;
        tick(); rsv_addr = 3'd7;
        tick(); idle(); a_addr = 3'd4; b_addr = 3'd5;
        #1;
        check("ar_cnt3", 2, 16'(cnt2), 16'h3);
        check("ar_data", 2, act_a[2], 16'hBEEF);
        check("ar_busy", 2, 16'(b_busy2), 16'h1);
        #3;
        rst_n = 1'b0;
        #2;
        check("ar_now_cnt", 2, 16'(cnt2), 16'h0);
        check("ar_now_adata", 2, act_a[2], 16'h0);
        check("ar_now_bbusy", 2, 16'(b_busy2), 16'h0);
        tick(); rst_n = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h1234;
        tick(); idle();
        #1;
        check("ar_first_wr", 2, act_a[2], 16'h1234);
        check("ar_first_cnt", 2, 16'(cnt2), 16'h0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n    = ($urandom_range(0, 249) != 0);
            wr_en    = ($urandom_range(0, 2) != 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 16'($urandom);
            rsv_en   = ($urandom_range(0, 1) != 0);
            rsv_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            a_addr   = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
            b_addr   = ($urandom_range(0, 4) == 0) ? a_addr  : 3'($urandom_range(0, 7));
        end

        tick(); rst_n = 1'b1; idle();
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
